// File: rtl/fsm_ascon_ctrl.sv
// ASCON-128 control FSM: sequences init (pa), optional AD, plaintext (pb) and finalization (pa).
// Define ASCON_AD_PHASE_EN to compile in a single associated-data block after INIT.
module fsm_ascon_ctrl (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic       last_block_i,
  input  logic [3:0] round_i,
  output logic       enable_cpt_o,
  output logic       init_a_o,
  output logic       init_b_o,
  output logic       en_state_o,
  output logic       sel_init_o,
  output logic       en_xor_key_begin_o,
  output logic       en_xor_data_begin_o,
  output logic       en_xor_key_end_o,
  output logic       en_xor_lsb_end_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       cipher_valid_o,
  output logic       busy_o,
  output logic       end_o
);

`ifdef ASCON_AD_PHASE_EN
  typedef enum logic [3:0] {
    IDLE, CONF_INIT, INIT, WAIT_AD, AD, WAIT_PT, PT, FIN, DONE
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE, CONF_INIT, INIT, WAIT_PT, PT, FIN, DONE
  } state_t;
`endif

  state_t state;
  logic   round_last;

  // A counter corrupted to 12..15 still ends the phase, so the FSM cannot hang.
  assign round_last = (round_i >= 4'd11);
  assign busy_o     = (state != IDLE);

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state          <= IDLE;
      cipher_valid_o <= 1'b0;
    end else begin
      cipher_valid_o <= en_cipher_o;
      case (state)
        IDLE:      if (start_i) state <= CONF_INIT;
        CONF_INIT: state <= INIT;
`ifdef ASCON_AD_PHASE_EN
        INIT:      if (round_last) state <= WAIT_AD;
        WAIT_AD:   if (data_valid_i) state <= AD;
        AD:        if (round_last) state <= WAIT_PT;
`else
        INIT:      if (round_last) state <= WAIT_PT;
`endif
        WAIT_PT:   if (data_valid_i) state <= last_block_i ? FIN : PT;
        PT:        if (round_last) state <= WAIT_PT;
        FIN:       if (round_last) state <= DONE;
        DONE:      state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_comb begin
    enable_cpt_o        = 1'b0;
    init_a_o            = 1'b0;
    init_b_o            = 1'b0;
    en_state_o          = 1'b0;
    sel_init_o          = 1'b0;
    en_xor_key_begin_o  = 1'b0;
    en_xor_data_begin_o = 1'b0;
    en_xor_key_end_o    = 1'b0;
    en_xor_lsb_end_o    = 1'b0;
    en_cipher_o         = 1'b0;
    en_tag_o            = 1'b0;
    end_o               = 1'b0;
    case (state)
      CONF_INIT: begin
        init_a_o     = 1'b1;
        enable_cpt_o = 1'b1;
      end
      INIT: begin
        en_state_o   = 1'b1;
        enable_cpt_o = 1'b1;
        sel_init_o   = (round_i == 4'd0);
        en_xor_key_end_o = round_last;
`ifndef ASCON_AD_PHASE_EN
        // Without an AD phase the domain-separation bit lands on the last INIT round.
        en_xor_lsb_end_o = round_last;
`endif
      end
`ifdef ASCON_AD_PHASE_EN
      WAIT_AD: begin
        init_b_o     = data_valid_i;
        enable_cpt_o = data_valid_i;
      end
      AD: begin
        en_state_o          = 1'b1;
        enable_cpt_o        = 1'b1;
        en_xor_data_begin_o = (round_i == 4'd6);
        en_xor_lsb_end_o    = round_last;
      end
`endif
      WAIT_PT: begin
        init_b_o     = data_valid_i & ~last_block_i;
        init_a_o     = data_valid_i &  last_block_i;
        enable_cpt_o = data_valid_i;
      end
      PT: begin
        en_state_o          = 1'b1;
        enable_cpt_o        = 1'b1;
        en_xor_data_begin_o = (round_i == 4'd6);
        en_cipher_o         = (round_i == 4'd6);
      end
      FIN: begin
        en_state_o          = 1'b1;
        enable_cpt_o        = 1'b1;
        en_xor_data_begin_o = (round_i == 4'd0);
        en_cipher_o         = (round_i == 4'd0);
        en_xor_key_begin_o  = (round_i == 4'd0);
        en_xor_key_end_o    = round_last;
        en_tag_o            = round_last;
      end
      DONE: end_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fsm_ascon_ctrl.sv
// Self-checking bench for fsm_ascon_ctrl; builds an expected per-cycle output trace from phase lengths.
// Honours ASCON_AD_PHASE_EN the same way the design does.
module tb_fsm_ascon_ctrl;

  logic       clock_i;
  logic       resetb_i;
  logic       start_i;
  logic       data_valid_i;
  logic       last_block_i;
  logic [3:0] round_i;
  logic       enable_cpt_o, init_a_o, init_b_o, en_state_o, sel_init_o;
  logic       en_xor_key_begin_o, en_xor_data_begin_o, en_xor_key_end_o, en_xor_lsb_end_o;
  logic       en_cipher_o, en_tag_o, cipher_valid_o, busy_o, end_o;

`ifdef ASCON_AD_PHASE_EN
  localparam bit HAS_AD = 1'b1;
`else
  localparam bit HAS_AD = 1'b0;
`endif

  localparam logic [13:0] B_EN   = 14'h2000;
  localparam logic [13:0] B_IA   = 14'h1000;
  localparam logic [13:0] B_IB   = 14'h0800;
  localparam logic [13:0] B_ST   = 14'h0400;
  localparam logic [13:0] B_SEL  = 14'h0200;
  localparam logic [13:0] B_KB   = 14'h0100;
  localparam logic [13:0] B_DB   = 14'h0080;
  localparam logic [13:0] B_KE   = 14'h0040;
  localparam logic [13:0] B_LSB  = 14'h0020;
  localparam logic [13:0] B_CI   = 14'h0010;
  localparam logic [13:0] B_TAG  = 14'h0008;
  localparam logic [13:0] B_CV   = 14'h0004;
  localparam logic [13:0] B_BUSY = 14'h0002;
  localparam logic [13:0] B_END  = 14'h0001;

  logic [13:0] obs;
  logic [13:0] exp_q[$];
  logic [13:0] exp_cur;
  logic        chk_en;
  logic        force_en;
  logic [3:0]  round_cnt;
  int          cur_cyc;
  int          first_wait, final_wait, pt0_start;
  int          n_compared = 0;
  int          n_failed = 0;

  fsm_ascon_ctrl dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i),
    .data_valid_i(data_valid_i), .last_block_i(last_block_i), .round_i(round_i),
    .enable_cpt_o(enable_cpt_o), .init_a_o(init_a_o), .init_b_o(init_b_o),
    .en_state_o(en_state_o), .sel_init_o(sel_init_o),
    .en_xor_key_begin_o(en_xor_key_begin_o), .en_xor_data_begin_o(en_xor_data_begin_o),
    .en_xor_key_end_o(en_xor_key_end_o), .en_xor_lsb_end_o(en_xor_lsb_end_o),
    .en_cipher_o(en_cipher_o), .en_tag_o(en_tag_o), .cipher_valid_o(cipher_valid_o),
    .busy_o(busy_o), .end_o(end_o)
  );

  assign obs = {enable_cpt_o, init_a_o, init_b_o, en_state_o, sel_init_o,
                en_xor_key_begin_o, en_xor_data_begin_o, en_xor_key_end_o,
                en_xor_lsb_end_o, en_cipher_o, en_tag_o, cipher_valid_o, busy_o, end_o};

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  // External round counter the FSM drives; round_i can be overridden to a corrupt value.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i)         round_cnt <= 4'd0;
    else if (init_a_o)     round_cnt <= 4'd0;
    else if (init_b_o)     round_cnt <= 4'd6;
    else if (enable_cpt_o) round_cnt <= round_cnt + 4'd1;
  end
  assign round_i = force_en ? 4'd14 : round_cnt;

  task automatic checkOutput(input logic [13:0] want, input string name, input int cyc);
    n_compared++;
    if (obs !== want) begin
      n_failed++;
      $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, obs, want);
    end
  endtask

  task automatic checkPin(input string name, input logic got, input logic want);
    n_compared++;
    if (got !== want) begin
      n_failed++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  always @(negedge clock_i) begin
    if (chk_en) checkOutput(exp_cur, "trace", cur_cyc);
  end

  // Expected outputs, one entry per cycle; cycle 0 is the cycle whose closing edge samples start_i.
  task automatic buildTrace(input int nblocks, input int stall, input int pt_len0);
    logic [13:0] v;
    int stall_left;
    stall_left = stall;
    exp_q.delete();
    pt0_start = -1;
    exp_q.push_back(14'h0000);
    exp_q.push_back(B_EN | B_IA | B_BUSY);
    for (int r = 0; r < 12; r++) begin
      v = B_EN | B_ST | B_BUSY;
      if (r == 0)  v |= B_SEL;
      if (r == 11) v |= HAS_AD ? B_KE : (B_KE | B_LSB);
      exp_q.push_back(v);
    end
    first_wait = exp_q.size();
    if (HAS_AD) begin
      repeat (stall_left) exp_q.push_back(B_BUSY);
      stall_left = 0;
      exp_q.push_back(B_EN | B_IB | B_BUSY);
      for (int r = 6; r < 12; r++) begin
        v = B_EN | B_ST | B_BUSY;
        if (r == 6)  v |= B_DB;
        if (r == 11) v |= B_LSB;
        exp_q.push_back(v);
      end
    end
    for (int b = 0; b < nblocks - 1; b++) begin
      repeat (stall_left) exp_q.push_back(B_BUSY);
      stall_left = 0;
      exp_q.push_back(B_EN | B_IB | B_BUSY);
      if (b == 0) pt0_start = exp_q.size();
      for (int j = 0; j < ((b == 0) ? pt_len0 : 6); j++) begin
        v = B_EN | B_ST | B_BUSY;
        if (j == 0) v |= B_DB | B_CI;
        exp_q.push_back(v);
      end
    end
    final_wait = exp_q.size();
    repeat (stall_left) exp_q.push_back(B_BUSY);
    exp_q.push_back(B_EN | B_IA | B_BUSY);
    for (int r = 0; r < 12; r++) begin
      v = B_EN | B_ST | B_BUSY;
      if (r == 0)  v |= B_DB | B_CI | B_KB;
      if (r == 11) v |= B_KE | B_TAG;
      exp_q.push_back(v);
    end
    exp_q.push_back(B_END | B_BUSY);
    repeat (3) exp_q.push_back(14'h0000);
    for (int c = exp_q.size() - 1; c > 0; c--)
      if ((exp_q[c-1] & B_CI) != 14'h0000) exp_q[c] = exp_q[c] | B_CV;
  endtask

  // Called just after a rising edge; returns just after a rising edge with reset released.
  task automatic applyStimulus(input int nblocks, input int stall, input int extra_start,
                               input bit do_force, input bit do_abort);
    int force_cyc, abort_cyc;
    buildTrace(nblocks, stall, do_force ? 2 : 6);
    force_cyc = do_force ? pt0_start + 1 : -1;
    abort_cyc = do_abort ? pt0_start + 2 : -1;
    for (int c = 0; c < exp_q.size(); c++) begin
      start_i      = (c == 0) || (c == extra_start);
      data_valid_i = !((c >= first_wait) && (c < first_wait + stall));
      last_block_i = (c >= final_wait);
      force_en     = (c == force_cyc);
      exp_cur      = exp_q[c];
      cur_cyc      = c;
      chk_en       = 1'b1;
      @(negedge clock_i);
      if (c == abort_cyc) begin
        #2;
        chk_en   = 1'b0;
        resetb_i = 1'b0;
        #1;
        checkOutput(14'h0000, "abort_async_reset", c);
        @(posedge clock_i);
        #1;
        checkOutput(14'h0000, "abort_held_reset", c + 1);
        resetb_i = 1'b1;
        start_i  = 1'b0;
        exp_cur  = 14'h0000;
        chk_en   = 1'b1;
        repeat (3) @(posedge clock_i);
        #1;
        chk_en = 1'b0;
        return;
      end
      @(posedge clock_i);
      #1;
    end
    chk_en   = 1'b0;
    start_i  = 1'b0;
    force_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    chk_en       = 1'b0;
    force_en     = 1'b0;
    exp_cur      = 14'h0000;
    cur_cyc      = 0;
    resetb_i     = 1'b0;
    start_i      = 1'b0;
    data_valid_i = 1'b0;
    last_block_i = 1'b0;
    #12;
    checkOutput(14'h0000, "reset_state", 0);
    @(posedge clock_i);
    #1;
    resetb_i = 1'b1;

    // Hand-computed anchors for the model itself.
    buildTrace(2, 0, 6);
    checkPin("model_conf_init_a",  exp_q[1][12], 1'b1);
    checkPin("model_sel_init_c2",  exp_q[2][9],  1'b1);
    checkPin("model_init_c13",     exp_q[13][10], 1'b1);
`ifdef ASCON_AD_PHASE_EN
    checkPin("model_ad_db_c15",    exp_q[15][7], 1'b1);
    checkPin("model_ad_lsb_c20",   exp_q[20][5], 1'b1);
    checkPin("model_end_c41",      exp_q[41][0], 1'b1);
    checkPin("model_len",          exp_q.size() == 45, 1'b1);
`else
    checkPin("model_init_b_c14",   exp_q[14][11], 1'b1);
    checkPin("model_cipher_c15",   exp_q[15][4], 1'b1);
    checkPin("model_cvalid_c16",   exp_q[16][2], 1'b1);
    checkPin("model_fin_init_a21", exp_q[21][12], 1'b1);
    checkPin("model_key_begin22",  exp_q[22][8], 1'b1);
    checkPin("model_tag_c33",      exp_q[33][3], 1'b1);
    checkPin("model_end_c34",      exp_q[34][0], 1'b1);
    checkPin("model_len",          exp_q.size() == 38, 1'b1);
`endif

    $display("[TB] nominal: two blocks, data always valid");
    applyStimulus(2, 0, -1, 1'b0, 1'b0);
    $display("[TB] stall: five idle cycles in first wait, three blocks");
    applyStimulus(3, 5, -1, 1'b0, 1'b0);
    $display("[TB] start pulse during INIT is ignored, single block");
    applyStimulus(1, 0, 5, 1'b0, 1'b0);
    $display("[TB] corrupt round 14 ends the PT phase");
    applyStimulus(2, 0, -1, 1'b1, 1'b0);
    $display("[TB] reset in PT at round 8, then fresh run");
    applyStimulus(2, 0, -1, 1'b0, 1'b1);
    applyStimulus(2, 0, -1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
